// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
package seg7_pkg;

  // Segment bit order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  // Hex glyphs 0..F; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Convert an active-high segment pattern to the pin polarity.
  function automatic logic [6:0] apply_seg_pol(input logic [6:0] seg, input logic act_lo);
    return act_lo ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to 7-segment pattern (active-high, gfedcba).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered digit data,
// per-slot dead time, optional leading-zero blanking, configurable polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int SEG_ACT_LO = 1,
  parameter int DIG_ACT_LO = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DATA_IN,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LOAD,
  input  logic                  BLANK_LEAD,
  output logic [6:0]            SEG_OUT,
  output logic                  DP_OUT,
  output logic [DIGITS-1:0]     DIG_OUT,
  output logic                  FRAME
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic              SEG_LO   = (SEG_ACT_LO != 0);
  localparam logic              DIG_LO   = (DIG_ACT_LO != 0);
  localparam logic [6:0]        SEG_IDLE = SEG_LO ? SEG_ALL : SEG_OFF;
  localparam logic              DP_IDLE  = SEG_LO;
  localparam logic [DIGITS-1:0] DIG_IDLE = DIG_LO ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          wrap;

  logic [DIGITS-1:0][3:0] pend_dig;
  logic [DIGITS-1:0][3:0] act_dig;
  logic [DIGITS-1:0]      pend_dp;
  logic [DIGITS-1:0]      act_dp;
  logic                   pend_vld;
  logic                   blank_en;

  logic [DIGITS-1:0] lead_zero;
  logic              zero_run;
  logic [3:0]        cur_dig;
  logic [6:0]        dec_seg;
  logic              in_dead;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [DIGITS-1:0] dig_nxt;

  assign slot_end = (presc == PW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(DIGITS - 1));
  assign FRAME    = wrap;

  // Prescaler and digit index; idx steps once per slot and wraps per frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= wrap ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Pending/active buffers: swap only at frame wrap so a frame never tears.
  // A LOAD coinciding with the wrap lands in pending and waits a full frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      act_dig  <= '0;
      act_dp   <= '0;
      blank_en <= 1'b0;
    end else begin
      if (wrap && pend_vld) begin
        act_dig  <= pend_dig;
        act_dp   <= pend_dp;
        blank_en <= BLANK_LEAD;
      end
      if (LOAD) begin
        pend_dig <= DATA_IN;
        pend_dp  <= DP_IN;
        pend_vld <= 1'b1;
      end else if (wrap) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Leading-zero mask: a digit is blanked while it and everything above are 0.
  always_comb begin
    lead_zero = '0;
    zero_run  = blank_en;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (act_dig[i] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  assign cur_dig = act_dig[idx];
  assign in_dead = (32'(presc) < 32'(BLANK_CYC));

  seg7_decode u_decode (
    .digit (cur_dig),
    .seg   (dec_seg)
  );

  // Slot contents in active-high form; dead time keeps everything dark.
  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    dig_nxt = '0;
    if (!in_dead) begin
      dig_nxt[idx] = 1'b1;
      seg_nxt      = lead_zero[idx] ? SEG_OFF : dec_seg;
      dp_nxt       = act_dp[idx];
    end
  end

  // Output register; polarity is applied only here so internals stay active-high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG_OUT <= SEG_IDLE;
      DP_OUT  <= DP_IDLE;
      DIG_OUT <= DIG_IDLE;
    end else begin
      SEG_OUT <= apply_seg_pol(seg_nxt, SEG_LO);
      DP_OUT  <= dp_nxt ^ SEG_LO;
      DIG_OUT <= dig_nxt ^ {DIGITS{DIG_LO}};
    end
  end

endmodule
